// File: rtl/mips16_loader.sv
// Host-to-Mips16 program loader: streams instruction words into the core, pulses its PC
// reset, then collects core results until a sentinel value or a cycle limit ends the session.
module mips16_loader #(
  parameter int          ADDR_W   = 8,
  parameter logic [15:0] SENTINEL = 16'h04D2,
  parameter int          TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              prog_valid,
  input  logic [15:0]       prog_data,
  input  logic              prog_last,
  output logic              prog_ready,
  output logic [15:0]       core_din,
  output logic              core_wen,
  output logic              core_pc_reset,
  output logic              core_rd_en,
  input  logic [15:0]       core_dout,
  output logic              res_valid,
  output logic [15:0]       res_data,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [ADDR_W:0]   word_count
);

  localparam int              CAPACITY = 1 << ADDR_W;
  localparam logic [ADDR_W:0] WC_LAST  = (ADDR_W+1)'(CAPACITY - 1);
  localparam logic [15:0]     RD_LAST  = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, PCRST, SETTLE, READ, DONE} state_t;

  state_t      state, state_next;
  logic [15:0] rd_cnt;
  logic        xfer;
  logic        launch;
  logic        is_sentinel;
  logic        rd_limit;

  assign xfer        = prog_valid && (state == LOAD);
  assign launch      = start && ((state == IDLE) || (state == DONE));
  assign is_sentinel = (core_dout == SENTINEL);
  assign rd_limit    = (rd_cnt == RD_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = LOAD;
      // prog_last and a full memory collapse into the same single move to PCRST
      LOAD:       if (xfer && (prog_last || word_count == WC_LAST)) state_next = PCRST;
      PCRST:      state_next = SETTLE;
      SETTLE:     state_next = READ;
      READ:       if (is_sentinel || rd_limit) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  assign prog_ready    = (state == LOAD);
  assign core_pc_reset = (state == PCRST);
  assign core_rd_en    = (state == READ);
  assign busy          = (state == LOAD) || (state == PCRST) || (state == SETTLE) || (state == READ);
  assign done          = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_din   <= '0;
      core_wen   <= 1'b0;
      word_count <= '0;
      rd_cnt     <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      timeout    <= 1'b0;
    end else begin
      core_wen  <= xfer;
      res_valid <= 1'b0;
      if (launch) begin
        word_count <= '0;
        rd_cnt     <= '0;
        timeout    <= 1'b0;
      end
      if (xfer) begin
        core_din   <= prog_data;
        word_count <= word_count + 1'b1;
      end
      // a sentinel on the last allowed cycle still counts as a clean stop
      if (state == READ) begin
        rd_cnt <= rd_cnt + 16'd1;
        if (!is_sentinel) begin
          res_valid <= 1'b1;
          res_data  <= core_dout;
          if (rd_limit) timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mips16_loader.sv
// Scoreboard bench for mips16_loader: stimulus queues expected core writes and results,
// a negedge monitor pops and compares them whenever the DUT strobes core_wen or res_valid.
module tb_mips16_loader;

  localparam int          ADDR_W   = 2;
  localparam logic [15:0] SENTINEL = 16'h04D2;
  localparam int          TIMEOUT  = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              prog_valid = 1'b0;
  logic [15:0]       prog_data = '0;
  logic              prog_last = 1'b0;
  logic              prog_ready;
  logic [15:0]       core_din;
  logic              core_wen;
  logic              core_pc_reset;
  logic              core_rd_en;
  logic [15:0]       core_dout = '0;
  logic              res_valid;
  logic [15:0]       res_data;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [ADDR_W:0]   word_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_wr[$];
  logic [15:0] exp_res[$];

  mips16_loader #(.ADDR_W(ADDR_W), .SENTINEL(SENTINEL), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start),
    .prog_valid(prog_valid), .prog_data(prog_data), .prog_last(prog_last),
    .prog_ready(prog_ready), .core_din(core_din), .core_wen(core_wen),
    .core_pc_reset(core_pc_reset), .core_rd_en(core_rd_en), .core_dout(core_dout),
    .res_valid(res_valid), .res_data(res_data), .busy(busy), .done(done),
    .timeout(timeout), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    exp_wr.push_back(d);
    prog_valid = 1'b1;
    prog_data  = d;
    prog_last  = last;
    tick();
    prog_valid = 1'b0;
    prog_last  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (core_wen) begin
        if (exp_wr.size() == 0) check("core_wen_unexpected", 32'(core_din), 32'hFFFF_FFFF);
        else check("core_din", 32'(core_din), 32'(exp_wr.pop_front()));
      end
      if (res_valid) begin
        if (exp_res.size() == 0) check("res_valid_unexpected", 32'(res_data), 32'hFFFF_FFFF);
        else check("res_data", 32'(res_data), 32'(exp_res.pop_front()));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #12;
    check("rst_busy", 32'(busy), 0);
    check("rst_prog_ready", 32'(prog_ready), 0);
    check("rst_wen", 32'(core_wen), 0);
    check("rst_rd_en", 32'(core_rd_en), 0);
    check("rst_word_count", 32'(word_count), 0);
    reset = 1'b1;
    tick();
    tick();
    check("idle_no_start_busy", 32'(busy), 0);

    // basic load: three back-to-back words, last on the third
    start = 1'b1;
    tick();
    start = 1'b0;
    check("load_ready", 32'(prog_ready), 1);
    check("load_busy", 32'(busy), 1);
    exp_wr.push_back(16'h2081);
    exp_wr.push_back(16'h2102);
    prog_valid = 1'b1; prog_data = 16'h2081; tick();
    prog_data = 16'h2102; tick();
    prog_valid = 1'b0;
    send(16'h0541, 1'b1);
    check("basic_word_count", 32'(word_count), 3);
    check("basic_pc_reset", 32'(core_pc_reset), 1);
    check("basic_ready_off", 32'(prog_ready), 0);
    tick();
    check("settle_pc_reset", 32'(core_pc_reset), 0);
    check("settle_rd_en", 32'(core_rd_en), 0);
    tick();
    check("read_rd_en", 32'(core_rd_en), 1);

    // sentinel stop
    exp_res.push_back(16'd1);
    exp_res.push_back(16'd2);
    exp_res.push_back(16'd3);
    core_dout = 16'd1; tick();
    core_dout = 16'd2; tick();
    core_dout = 16'd3; tick();
    core_dout = SENTINEL; tick();
    core_dout = 16'd0;
    check("sent_done", 32'(done), 1);
    check("sent_timeout", 32'(timeout), 0);
    check("sent_busy", 32'(busy), 0);
    check("sent_rd_en", 32'(core_rd_en), 0);
    check("sent_res_valid", 32'(res_valid), 0);
    check("done_hold_wc", 32'(word_count), 3);
    check("done_hold_res", 32'(res_data), 3);

    // gaps, ignored start, capacity stop
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_wc", 32'(word_count), 0);
    check("restart_done", 32'(done), 0);
    send(16'h1111, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("gap1_wen", 32'(core_wen), 0);
    check("gap1_wc", 32'(word_count), 1);
    check("start_ignored_ready", 32'(prog_ready), 1);
    tick();
    check("gap2_wen", 32'(core_wen), 0);
    check("gap2_wc", 32'(word_count), 1);
    exp_wr.push_back(16'h2222);
    exp_wr.push_back(16'h3333);
    prog_valid = 1'b1; prog_data = 16'h2222; tick();
    prog_data = 16'h3333; tick();
    prog_valid = 1'b0;
    send(16'h4444, 1'b0);
    check("cap_word_count", 32'(word_count), 4);
    check("cap_pc_reset", 32'(core_pc_reset), 1);
    check("cap_ready_off", 32'(prog_ready), 0);
    tick();
    check("cap_settle_ready", 32'(prog_ready), 0);
    tick();

    // timeout with a constant non-sentinel result
    core_dout = 16'h0007;
    for (int i = 0; i < TIMEOUT; i++) exp_res.push_back(16'h0007);
    repeat (TIMEOUT - 1) tick();
    check("to_still_busy", 32'(busy), 1);
    check("to_not_yet", 32'(timeout), 0);
    tick();
    check("to_done", 32'(done), 1);
    check("to_timeout", 32'(timeout), 1);
    check("to_rd_en", 32'(core_rd_en), 0);
    core_dout = 16'd0;
    tick();
    check("to_res_drained", exp_res.size(), 0);

    // reset in the middle of READ
    start = 1'b1;
    tick();
    start = 1'b0;
    check("s3_timeout_cleared", 32'(timeout), 0);
    send(16'hABCD, 1'b1);
    tick();
    tick();
    exp_res.push_back(16'h0005);
    core_dout = 16'h0005;
    tick();
    #5;
    reset = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_rd_en", 32'(core_rd_en), 0);
    check("mid_rst_res_valid", 32'(res_valid), 0);
    check("mid_rst_res_data", 32'(res_data), 0);
    check("mid_rst_din", 32'(core_din), 0);
    check("mid_rst_wc", 32'(word_count), 0);
    check("mid_rst_done", 32'(done), 0);
    core_dout = 16'd0;
    #10;
    reset = 1'b1;
    tick();
    check("post_rst_idle", 32'(busy), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("reload_wc0", 32'(word_count), 0);
    send(16'h0F0F, 1'b0);
    check("reload_wc1", 32'(word_count), 1);
    send(16'hF0F0, 1'b1);
    check("reload_wc2", 32'(word_count), 2);
    check("reload_pc_reset", 32'(core_pc_reset), 1);
    tick();
    tick();
    core_dout = SENTINEL;
    tick();
    core_dout = 16'd0;
    check("reload_done", 32'(done), 1);
    check("reload_timeout", 32'(timeout), 0);
    tick();
    check("wr_queue_empty", exp_wr.size(), 0);
    check("res_queue_empty", exp_res.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
